// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES job scheduler.
// Imported by the arbiter and the scheduler top.
package aes_sched_pkg;

  localparam int AES_W = 128;

  localparam logic OP_ENC = 1'b0;
  localparam logic OP_DEC = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Id width for n requesters, never below one bit.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_job_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first request after last.
// The scheduler registers the result, so no state lives here.
module rr_arbiter
  import aes_sched_pkg::*;
#(
  parameter  int N   = 2,
  localparam int IDW = idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  input  logic           enable,
  output logic [IDW-1:0] gnt_idx,
  output logic           gnt_any
);

  logic [2*N-1:0] rot;
  int             base;

  // Rotate so bit 0 is the requester right after last, then take the first set bit.
  always_comb begin
    base    = int'(last) + 1;
    rot     = {req, req} >> base;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (enable && !gnt_any && rot[k]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'((base + k) % N);
      end
    end
  end

endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one AES encrypt and one AES decrypt engine among requesters.
// One job at a time, round-robin grant, watchdog abort on hung runs.
module aes_job_scheduler
  import aes_sched_pkg::*;
#(
  parameter  int NREQ           = 2,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IDW            = idw(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ*AES_W-1:0] req_data,
  input  logic [NREQ*AES_W-1:0] req_key,
  output logic [AES_W-1:0]      eng_data,
  output logic [AES_W-1:0]      eng_key,
  output logic                  enc_start,
  input  logic                  enc_done,
  input  logic [AES_W-1:0]      enc_result,
  output logic                  dec_start,
  input  logic                  dec_done,
  input  logic [AES_W-1:0]      dec_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [AES_W-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_error,
  output logic                  busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  state_t             state;
  logic               op;
  logic [IDW-1:0]     last_grant;
  logic [CW-1:0]      cnt;
  logic [IDW-1:0]     gnt_idx;
  logic               gnt_any;
  logic [AES_W-1:0]   sel_data;
  logic [AES_W-1:0]   sel_key;
  logic               sel_op;
  logic               done_sel;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req     (req_valid),
    .last    (last_grant),
    .enable  (state == S_IDLE),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Pick the granted requester's job fields; other slices are never sampled.
  always_comb begin
    sel_data = '0;
    sel_key  = '0;
    sel_op   = OP_ENC;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_data = req_data[i*AES_W +: AES_W];
        sel_key  = req_key[i*AES_W +: AES_W];
        sel_op   = req_op[i];
      end
    end
  end

  assign done_sel = (op == OP_DEC) ? dec_done : enc_done;
  assign busy     = (state != S_IDLE);

  // Job FSM: accept, run engine with watchdog, hold response until taken.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      req_ready  <= '0;
      eng_data   <= '0;
      eng_key    <= '0;
      op         <= OP_ENC;
      last_grant <= IDW'(NREQ - 1);
      cnt        <= '0;
      enc_start  <= 1'b0;
      dec_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= '0;
      rsp_error  <= 1'b0;
    end else begin
      req_ready <= '0;
      unique case (state)
        S_IDLE: begin
          if (gnt_any) begin
            req_ready  <= NREQ'(1) << gnt_idx;
            eng_data   <= sel_data;
            eng_key    <= sel_key;
            op         <= sel_op;
            rsp_id     <= gnt_idx;
            last_grant <= gnt_idx;
            cnt        <= '0;
            enc_start  <= (sel_op == OP_ENC);
            dec_start  <= (sel_op == OP_DEC);
            state      <= S_RUN;
          end
        end
        S_RUN: begin
          if (done_sel) begin
            rsp_data  <= (op == OP_DEC) ? dec_result : enc_result;
            rsp_error <= 1'b0;
            rsp_valid <= 1'b1;
            enc_start <= 1'b0;
            dec_start <= 1'b0;
            state     <= S_RESP;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            rsp_data  <= '0;
            rsp_error <= 1'b1;
            rsp_valid <= 1'b1;
            enc_start <= 1'b0;
            dec_start <= 1'b0;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Self-checking bench for aes_job_scheduler with a behavioural
// engine model and a round-robin/scoreboard reference model.
module tb_aes_job_scheduler;
  import aes_sched_pkg::*;

  localparam int NREQ = 2;
  localparam int TMO  = 16;
  localparam int IDW  = 1;
  typedef logic [IDW-1:0] rid_t;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_op;
  logic [NREQ-1:0][127:0] jd;
  logic [NREQ-1:0][127:0] jk;
  logic [NREQ*128-1:0]    req_data;
  logic [NREQ*128-1:0]    req_key;
  logic [127:0]           eng_data;
  logic [127:0]           eng_key;
  logic                   enc_start;
  logic                   enc_done;
  logic [127:0]           enc_result;
  logic                   dec_start;
  logic                   dec_done;
  logic [127:0]           dec_result;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [127:0]           rsp_data;
  rid_t                   rsp_id;
  logic                   rsp_error;
  logic                   busy;

  int   lat = 12;
  logic enc_inj = 1'b0;
  int   ecnt = 0;
  int   dcnt = 0;
  int   npass = 0;
  int   ntot = 0;

  always #5 clock = ~clock;

  assign req_data = jd;
  assign req_key  = jk;

  aes_job_scheduler #(.NREQ(NREQ), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_key(req_key),
    .eng_data(eng_data), .eng_key(eng_key),
    .enc_start(enc_start), .enc_done(enc_done), .enc_result(enc_result),
    .dec_start(dec_start), .dec_done(dec_done), .dec_result(dec_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_error(rsp_error), .busy(busy)
  );

  function automatic logic [127:0] enc_fn(input logic [127:0] d, input logic [127:0] k);
    if (d == PT && k == KEY) return CT;
    return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0000_ffff_1234_0f0f_aaaa_5555_9999;
  endfunction

  function automatic logic [127:0] dec_fn(input logic [127:0] d, input logic [127:0] k);
    if (d == CT && k == KEY) return PT;
    return d ^ k ^ 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  endfunction

  // Engine model: done in the lat-th cycle of a held start.
  always @(posedge clock) begin
    ecnt <= enc_start ? ecnt + 1 : 0;
    dcnt <= dec_start ? dcnt + 1 : 0;
  end

  assign enc_done   = (enc_start && ecnt == lat - 1) || enc_inj;
  assign dec_done   = dec_start && dcnt == lat - 1;
  assign enc_result = enc_fn(eng_data, eng_key);
  assign dec_result = dec_fn(eng_data, eng_key);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    enc_inj   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run_job(input rid_t rq, input logic op, input logic [127:0] d,
                         input logic [127:0] k, input int l,
                         output logic [NREQ-1:0] rdy, output logic [NREQ-1:0] rdy2,
                         output int nst, output logic wrong, output logic got,
                         output logic [127:0] rd, output rid_t rid, output logic rerr);
    lat = l;
    rsp_ready = 1'b1;
    req_op[rq] = op;
    jd[rq] = d;
    jk[rq] = k;
    req_valid[rq] = 1'b1;
    rdy = '0; rdy2 = '0; nst = 0; wrong = 1'b0;
    got = 1'b0; rd = '0; rid = '0; rerr = 1'b0;
    for (int c = 0; c < 20 && rdy == '0; c++) begin
      @(negedge clock);
      rdy = req_ready;
    end
    req_valid[rq] = 1'b0;
    if (rdy != '0) begin
      for (int c = 0; c < 2000 && (enc_start || dec_start); c++) begin
        if (nst == 1) rdy2 = req_ready;
        nst++;
        if ((op == OP_ENC && dec_start) || (op == OP_DEC && enc_start)) wrong = 1'b1;
        @(negedge clock);
      end
      got = rsp_valid; rd = rsp_data; rid = rsp_id; rerr = rsp_error;
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = '0; req_op = '0; jd = '0; jk = '0; rsp_ready = 1'b0;
    #1;
    ntot++;
    if ({req_ready, enc_start, dec_start, rsp_valid, busy} !== '0)
      $display("FAIL reset_ctrl: got %b want 0", {req_ready, enc_start, dec_start, rsp_valid, busy});
    else npass++;
    tick();
    ntot++;
    if (rsp_data !== '0 || rsp_id !== '0 || rsp_error !== 1'b0 || eng_data !== '0 || eng_key !== '0)
      $display("FAIL reset_data: rsp_data %h id %0d err %b eng %h want zeros", rsp_data, rsp_id, rsp_error, eng_data);
    else npass++;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_encrypt();
    logic [NREQ-1:0] rdy, rdy2; int nst; logic wrong, got, rerr; logic [127:0] rd; rid_t rid;
    run_job(1'b0, OP_ENC, PT, KEY, 12, rdy, rdy2, nst, wrong, got, rd, rid, rerr);
    ntot++; if (rdy !== 2'b01) $display("FAIL enc_grant: got %b want 01", rdy); else npass++;
    ntot++; if (rdy2 !== 2'b00) $display("FAIL enc_ready_pulse: got %b want 00", rdy2); else npass++;
    ntot++; if (nst !== 12) $display("FAIL enc_start_len: got %0d want 12", nst); else npass++;
    ntot++; if (wrong !== 1'b0) $display("FAIL enc_route: dec_start seen"); else npass++;
    ntot++;
    if (got !== 1'b1 || rd !== CT || rid !== 1'b0 || rerr !== 1'b0)
      $display("FAIL enc_rsp: v %b data %h id %0d err %b want 1 %h 0 0", got, rd, rid, rerr, CT);
    else npass++;
    ntot++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL enc_idle: rsp_valid %b busy %b want 0 0", rsp_valid, busy);
    else npass++;
  endtask

  task automatic test_decrypt();
    logic [NREQ-1:0] rdy, rdy2; int nst; logic wrong, got, rerr; logic [127:0] rd; rid_t rid;
    enc_inj = 1'b1;
    run_job(1'b1, OP_DEC, CT, KEY, 9, rdy, rdy2, nst, wrong, got, rd, rid, rerr);
    enc_inj = 1'b0;
    ntot++; if (rdy !== 2'b10) $display("FAIL dec_grant: got %b want 10", rdy); else npass++;
    ntot++; if (nst !== 9) $display("FAIL dec_start_len: got %0d want 9", nst); else npass++;
    ntot++; if (wrong !== 1'b0) $display("FAIL dec_route: enc_start seen"); else npass++;
    ntot++;
    if (got !== 1'b1 || rd !== PT || rid !== 1'b1 || rerr !== 1'b0)
      $display("FAIL dec_rsp: v %b data %h id %0d err %b want 1 %h 1 0", got, rd, rid, rerr, PT);
    else npass++;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] seen;
    logic [127:0] exp_d;
    rid_t e;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      e = rid_t'(i);
      jd[e] = {4{$urandom}};
      jk[e] = {4{$urandom}};
      req_op[e] = 1'($urandom_range(0, 1));
    end
    lat = $urandom_range(2, 6);
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int j = 0; j < 4; j++) begin
      e = rid_t'(j % NREQ);
      seen = '0;
      for (int c = 0; c < 40 && seen == '0; c++) begin
        @(negedge clock);
        seen = req_ready;
      end
      ntot++;
      if (seen !== (NREQ'(1) << e)) $display("FAIL rr_grant%0d: got %b want %b", j, seen, NREQ'(1) << e);
      else npass++;
      for (int c = 0; c < 40 && !rsp_valid; c++) @(negedge clock);
      exp_d = req_op[e] ? dec_fn(jd[e], jk[e]) : enc_fn(jd[e], jk[e]);
      ntot++;
      if (rsp_valid !== 1'b1 || rsp_id !== e || rsp_data !== exp_d)
        $display("FAIL rr_rsp%0d: v %b id %0d data %h want 1 %0d %h", j, rsp_valid, rsp_id, rsp_data, e, exp_d);
      else npass++;
      tick();
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] rdy, rdy2; int nst; logic wrong, got, rerr; logic [127:0] rd, d, k; rid_t rid;
    run_job(1'b0, OP_ENC, {4{$urandom}}, {4{$urandom}}, 1000, rdy, rdy2, nst, wrong, got, rd, rid, rerr);
    ntot++; if (nst !== TMO) $display("FAIL tmo_len: got %0d want %0d", nst, TMO); else npass++;
    ntot++;
    if (got !== 1'b1 || rerr !== 1'b1 || rd !== '0 || rid !== 1'b0)
      $display("FAIL tmo_rsp: v %b err %b data %h id %0d want 1 1 0 0", got, rerr, rd, rid);
    else npass++;
    d = {4{$urandom}};
    k = {4{$urandom}};
    run_job(1'b1, OP_DEC, d, k, 5, rdy, rdy2, nst, wrong, got, rd, rid, rerr);
    ntot++;
    if (rdy !== 2'b10 || rerr !== 1'b0 || rd !== dec_fn(d, k) || nst !== 5)
      $display("FAIL tmo_next: rdy %b err %b data %h len %0d want 10 0 %h 5", rdy, rerr, rd, nst, dec_fn(d, k));
    else npass++;
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] seen;
    logic [127:0] d0;
    rid_t i0;
    logic e0, stable, noready, nostart;
    lat = 4;
    rsp_ready = 1'b0;
    req_op[0] = OP_ENC; jd[0] = PT; jk[0] = KEY;
    req_valid = 2'b01;
    for (int c = 0; c < 40 && !rsp_valid; c++) @(negedge clock);
    d0 = rsp_data; e0 = rsp_error; i0 = rsp_id;
    stable = 1'b1; noready = 1'b1; nostart = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== d0 || rsp_error !== e0 || rsp_id !== i0) stable = 1'b0;
      if (req_ready !== '0) noready = 1'b0;
      if (enc_start !== 1'b0 || dec_start !== 1'b0) nostart = 1'b0;
      @(negedge clock);
    end
    ntot++;
    if (stable !== 1'b1 || d0 !== CT || e0 !== 1'b0 || i0 !== 1'b0)
      $display("FAIL bp_hold: stable %b data %h err %b id %0d want 1 %h 0 0", stable, d0, e0, i0, CT);
    else npass++;
    ntot++; if (noready !== 1'b1) $display("FAIL bp_no_grant: got pulse want none"); else npass++;
    ntot++; if (nostart !== 1'b1) $display("FAIL bp_no_start: got start want 0"); else npass++;
    rsp_ready = 1'b1;
    @(negedge clock);
    ntot++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL bp_release: rsp_valid %b busy %b want 0 0", rsp_valid, busy);
    else npass++;
    seen = '0;
    for (int c = 0; c < 3 && seen == '0; c++) begin
      @(negedge clock);
      seen = req_ready;
    end
    req_valid = '0;
    ntot++; if (seen !== 2'b01) $display("FAIL bp_next_grant: got %b want 01", seen); else npass++;
    for (int c = 0; c < 40 && !rsp_valid; c++) @(negedge clock);
    ntot++; if (rsp_data !== CT) $display("FAIL bp_next_rsp: got %h want %h", rsp_data, CT); else npass++;
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic [NREQ-1:0] seen;
    rsp_ready = 1'b1;
    lat = 50;
    req_op[0] = OP_ENC; jd[0] = {4{$urandom}}; jk[0] = {4{$urandom}};
    req_valid = 2'b01;
    seen = '0;
    for (int c = 0; c < 20 && seen == '0; c++) begin
      @(negedge clock);
      seen = req_ready;
    end
    req_valid = '0;
    repeat (4) @(negedge clock);
    ntot++; if (enc_start !== 1'b1) $display("FAIL mid_run_start: got %b want 1", enc_start); else npass++;
    reset = 1'b1;
    #1;
    ntot++;
    if ({enc_start, dec_start, rsp_valid, busy, req_ready} !== '0)
      $display("FAIL mid_reset_out: got %b want 0", {enc_start, dec_start, rsp_valid, busy, req_ready});
    else npass++;
    tick();
    req_op = 2'b00;
    jd[1] = {4{$urandom}}; jk[1] = {4{$urandom}};
    req_valid = 2'b11;
    reset = 1'b0;
    seen = '0;
    for (int c = 0; c < 20 && seen == '0; c++) begin
      @(negedge clock);
      seen = req_ready;
    end
    lat = 3;
    req_valid = '0;
    ntot++; if (seen !== 2'b01) $display("FAIL mid_first_grant: got %b want 01", seen); else npass++;
    for (int c = 0; c < 40 && !rsp_valid; c++) @(negedge clock);
    ntot++;
    if (rsp_id !== 1'b0 || rsp_data !== enc_fn(jd[0], jk[0]))
      $display("FAIL mid_rsp: id %0d data %h want 0 %h", rsp_id, rsp_data, enc_fn(jd[0], jk[0]));
    else npass++;
    tick();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] pend, pmask;
    logic [127:0] qd[$];
    logic qe[$];
    rid_t qi[$];
    rid_t g, r;
    int rr, got, eg, l;
    do_reset();
    pend = '0; pmask = '0; rr = NREQ - 1; got = 0;
    for (int cyc = 0; cyc < 1600; cyc++) begin
      @(negedge clock);
      if (req_ready != '0) begin
        eg = -1;
        for (int k = 1; k <= NREQ; k++)
          if (eg < 0 && pmask[rid_t'((rr + k) % NREQ)]) eg = (rr + k) % NREQ;
        ntot++;
        if (eg < 0 || req_ready !== (NREQ'(1) << eg))
          $display("FAIL rnd_grant: got %b want idx %0d mask %b", req_ready, eg, pmask);
        else npass++;
        if (eg >= 0) begin
          g = rid_t'(eg);
          rr = eg;
          l = $urandom_range(1, 18);
          lat = l;
          ntot++;
          if (enc_start !== (req_op[g] == OP_ENC) || dec_start !== (req_op[g] == OP_DEC))
            $display("FAIL rnd_start: enc %b dec %b op %b", enc_start, dec_start, req_op[g]);
          else npass++;
          qi.push_back(g);
          qe.push_back(l > TMO);
          qd.push_back((l > TMO) ? '0 : (req_op[g] ? dec_fn(jd[g], jk[g]) : enc_fn(jd[g], jk[g])));
          pend[g] = 1'b0;
        end
      end
      if (rsp_valid && rsp_ready) begin
        got++;
        ntot++;
        if (qd.size() == 0) $display("FAIL rnd_rsp: unexpected response id %0d", rsp_id);
        else begin
          if (rsp_id !== qi[0] || rsp_error !== qe[0] || rsp_data !== qd[0])
            $display("FAIL rnd_rsp: id %0d err %b data %h want %0d %b %h",
                     rsp_id, rsp_error, rsp_data, qi[0], qe[0], qd[0]);
          else npass++;
          void'(qd.pop_front()); void'(qe.pop_front()); void'(qi.pop_front());
        end
      end
      pmask = req_valid;
      tick();
      for (int i = 0; i < NREQ; i++) begin
        r = rid_t'(i);
        if (!pend[r] && cyc < 1300 && $urandom_range(0, 3) == 0) begin
          pend[r] = 1'b1;
          req_op[r] = 1'($urandom_range(0, 1));
          jd[r] = {4{$urandom}};
          jk[r] = {4{$urandom}};
        end
      end
      req_valid = pend;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    ntot++;
    if (qd.size() != 0 || got < 20)
      $display("FAIL rnd_drain: pending %0d responses %0d want 0 and >=20", qd.size(), got);
    else npass++;
  endtask

  initial begin
    test_reset();
    test_single_encrypt();
    test_decrypt();
    test_round_robin();
    test_timeout();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
